// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for a streaming Sobel datapath: raster-scans input pixels,
// tracks pipeline latency and flags border outputs that downstream zeroes.
module sobel_frame_ctrl #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int LATENCY = 537
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  input  logic       iStall,
  output logic       oInValid,
  output logic [9:0] oInX,
  output logic [8:0] oInY,
  output logic       oSof,
  output logic       oEol,
  output logic       oOutValid,
  output logic       oOutBorder,
  output logic       oBusy,
  output logic       oDone
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int LW   = $clog2(NPIX + 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t          state;
  logic [9:0]      in_x, out_x;
  logic [8:0]      in_y, out_y;
  logic [LW-1:0]   lat_cnt;
  logic            out_started;

  logic active, in_fire, out_phase, out_fire, in_last, out_last, out_edge;

  assign active    = ((state == FEED) || (state == DRAIN)) && !iStall;
  assign in_fire   = active && (state == FEED);
  // Output phase opens on the active cycle LATENCY active cycles after SOF.
  assign out_phase = out_started || (lat_cnt == LW'(LATENCY));
  assign out_fire  = active && out_phase;
  assign in_last   = (in_x == 10'(IMG_W - 1)) && (in_y == 9'(IMG_H - 1));
  assign out_last  = (out_x == 10'(IMG_W - 1)) && (out_y == 9'(IMG_H - 1));
  assign out_edge  = (out_x == 10'd0) || (out_x == 10'(IMG_W - 1)) ||
                     (out_y == 9'd0)  || (out_y == 9'(IMG_H - 1));

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= IDLE;
      in_x        <= '0;
      in_y        <= '0;
      out_x       <= '0;
      out_y       <= '0;
      lat_cnt     <= '0;
      out_started <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) state <= FEED;
        end
        FEED, DRAIN: begin
          if (in_fire) begin
            if (in_x == 10'(IMG_W - 1)) begin
              in_x <= '0;
              in_y <= in_last ? 9'd0 : in_y + 9'd1;
            end else begin
              in_x <= in_x + 10'd1;
            end
            if (in_last) state <= DRAIN;
          end
          if (active && !out_phase) lat_cnt <= lat_cnt + 1'b1;
          if (out_fire) begin
            out_started <= 1'b1;
            if (out_x == 10'(IMG_W - 1)) begin
              out_x <= '0;
              out_y <= out_last ? 9'd0 : out_y + 9'd1;
            end else begin
              out_x <= out_x + 10'd1;
            end
            // Last output closes the frame and rearms the latency tracker.
            if (out_last) begin
              state       <= DONE;
              out_started <= 1'b0;
              lat_cnt     <= '0;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign oInValid   = in_fire;
  assign oInX       = (state == FEED) ? in_x : 10'd0;
  assign oInY       = (state == FEED) ? in_y : 9'd0;
  assign oSof       = in_fire && (in_x == 10'd0) && (in_y == 9'd0);
  assign oEol       = in_fire && (in_x == 10'(IMG_W - 1));
  assign oOutValid  = out_fire;
  assign oOutBorder = out_fire && out_edge;
  assign oBusy      = (state != IDLE);
  assign oDone      = (state == DONE);

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl on an 8x4 image with latency 5,
// using coordinate/border scoreboards plus per-scenario timing checks.
module tb_sobel_frame_ctrl;

  localparam int W = 8;
  localparam int H = 4;
  localparam int L = 5;

  logic       clk, rst, start, stall;
  logic       oInValid, oSof, oEol, oOutValid, oOutBorder, oBusy, oDone;
  logic [9:0] oInX;
  logic [8:0] oInY;

  int total = 0;
  int bad   = 0;
  bit mon_en;

  int in_xq[$], in_yq[$], bord_q[$];
  int mx, my, mb;

  int sof_cyc, sof_cnt, n_in, n_out, first_out, last_out, done_cyc, done_cnt;
  int n_border, y_at8, stall_valid;
  int eol_idx[$];
  int stall_x[$];
  logic busy_after;
  logic [25:0] rst_snap;

  sobel_frame_ctrl #(.IMG_W(W), .IMG_H(H), .LATENCY(L)) dut (
    .iClk(clk), .iRst(rst), .iStart(start), .iStall(stall),
    .oInValid(oInValid), .oInX(oInX), .oInY(oInY), .oSof(oSof), .oEol(oEol),
    .oOutValid(oOutValid), .oOutBorder(oOutBorder), .oBusy(oBusy), .oDone(oDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: pops expected input coordinates and output border flags.
  always @(negedge clk) begin
    if (mon_en) begin
      if (oInValid) begin
        total++;
        if (in_xq.size() == 0) begin
          bad++;
          $display("[TB] FAIL in_extra got x=%0d y=%0d want no input", oInX, oInY);
        end else begin
          mx = in_xq.pop_front();
          my = in_yq.pop_front();
          if (oInX !== mx[9:0] || oInY !== my[8:0]) begin
            bad++;
            $display("[TB] FAIL in_coord got x=%0d y=%0d want x=%0d y=%0d", oInX, oInY, mx, my);
          end
        end
      end
      if (oOutValid) begin
        total++;
        if (bord_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL out_extra got border=%0b want no output", oOutBorder);
        end else begin
          mb = bord_q.pop_front();
          if (oOutBorder !== mb[0]) begin
            bad++;
            $display("[TB] FAIL out_border got %0b want %0b", oOutBorder, mb[0]);
          end
        end
      end
    end
  end

  task automatic push_frame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        in_xq.push_back(x);
        in_yq.push_back(y);
        bord_q.push_back((x == 0 || x == W-1 || y == 0 || y == H-1) ? 1 : 0);
      end
  endtask

  task automatic flush_queues();
    in_xq.delete();
    in_yq.delete();
    bord_q.delete();
  endtask

  // Cycle 0 carries the start request; stall/reset are scheduled by cycle.
  task automatic run_frame(input int stall_c, input int stall_n, input bit hold_start, input int rst_c);
    bit finished = 0;
    sof_cyc = -1; sof_cnt = 0; n_in = 0; n_out = 0; first_out = -1; last_out = -1;
    done_cyc = -1; done_cnt = 0; n_border = 0; y_at8 = -1; stall_valid = 0;
    busy_after = 1'bx; rst_snap = 'x;
    eol_idx.delete();
    stall_x.delete();
    for (int c = 0; c < 300 && !finished; c++) begin
      @(posedge clk); #1;
      start = (c == 0) || hold_start;
      stall = (c >= stall_c) && (c < stall_c + stall_n);
      rst   = (c == rst_c);
      @(negedge clk);
      if (rst_c >= 0 && c == rst_c + 1) begin
        rst_snap = {oInValid, oInX, oInY, oSof, oEol, oOutValid, oOutBorder, oBusy, oDone};
        finished = 1;
      end
      if (oSof) begin
        sof_cnt++;
        if (sof_cyc < 0) sof_cyc = c;
      end
      if (oInValid) begin
        if (oEol) eol_idx.push_back(n_in);
        if (n_in == 8) y_at8 = int'(oInY);
        n_in++;
      end
      if (oOutValid) begin
        if (first_out < 0) first_out = c;
        last_out = c;
        if (oOutBorder) n_border++;
        n_out++;
      end
      if (stall) begin
        if (oInValid) stall_valid++;
        stall_x.push_back(int'(oInX));
      end
      if (oDone) begin
        done_cnt++;
        done_cyc = c;
      end
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        busy_after = oBusy;
        finished = 1;
      end
    end
    if (!finished) begin
      total++; bad++;
      $display("[TB] FAIL frame_timeout got no completion within 300 cycles want done");
    end
    start = 1'b0; stall = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({oInValid, oInX, oInY, oSof, oEol, oOutValid, oOutBorder, oBusy, oDone} !== 26'd0) begin
      bad++; $display("[TB] FAIL reset_outputs got %h want 0", {oInValid, oInX, oInY, oSof, oEol, oOutValid, oOutBorder, oBusy, oDone});
    end
    start = 1'b1;
    @(negedge clk);
    total++;
    if (oBusy !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_priority got busy=%0b want 0", oBusy);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    total++;
    if (oBusy !== 1'b0) begin
      bad++; $display("[TB] FAIL idle_hold got busy=%0b want 0", oBusy);
    end
  endtask

  task automatic test_nominal();
    push_frame();
    run_frame(-1, 0, 1'b0, -1);
    total++; if (sof_cyc !== 1)    begin bad++; $display("[TB] FAIL sof_cycle got %0d want 1", sof_cyc); end
    total++; if (sof_cnt !== 1)    begin bad++; $display("[TB] FAIL sof_count got %0d want 1", sof_cnt); end
    total++; if (n_in !== 32)      begin bad++; $display("[TB] FAIL in_count got %0d want 32", n_in); end
    total++; if (first_out !== 6)  begin bad++; $display("[TB] FAIL first_out got %0d want 6", first_out); end
    total++; if (last_out !== 37)  begin bad++; $display("[TB] FAIL last_out got %0d want 37", last_out); end
    total++; if (n_out !== 32)     begin bad++; $display("[TB] FAIL out_count got %0d want 32", n_out); end
    total++; if (done_cyc !== 38)  begin bad++; $display("[TB] FAIL done_cycle got %0d want 38", done_cyc); end
    total++; if (done_cnt !== 1)   begin bad++; $display("[TB] FAIL done_count got %0d want 1", done_cnt); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("[TB] FAIL busy_after_done got %0b want 0", busy_after); end
    total++; if (n_border !== 20)  begin bad++; $display("[TB] FAIL border_count got %0d want 20", n_border); end
    total++; if (eol_idx.size() !== 4) begin bad++; $display("[TB] FAIL eol_count got %0d want 4", eol_idx.size()); end
    for (int i = 0; i < 4 && i < eol_idx.size(); i++) begin
      total++;
      if (eol_idx[i] !== 8*i + 7) begin bad++; $display("[TB] FAIL eol_index got %0d want %0d", eol_idx[i], 8*i + 7); end
    end
    total++; if (y_at8 !== 1) begin bad++; $display("[TB] FAIL y_wrap got %0d want 1", y_at8); end
    total++; if (in_xq.size() + bord_q.size() !== 0) begin bad++; $display("[TB] FAIL sb_leftover got %0d want 0", in_xq.size() + bord_q.size()); end
    flush_queues();
  endtask

  task automatic test_stall();
    push_frame();
    run_frame(12, 3, 1'b0, -1);
    total++; if (stall_valid !== 0) begin bad++; $display("[TB] FAIL stall_valid got %0d want 0", stall_valid); end
    total++; if (stall_x.size() !== 3) begin bad++; $display("[TB] FAIL stall_len got %0d want 3", stall_x.size()); end
    for (int i = 0; i < stall_x.size(); i++) begin
      total++;
      if (stall_x[i] !== 3) begin bad++; $display("[TB] FAIL stall_x got %0d want 3", stall_x[i]); end
    end
    total++; if (done_cyc !== 41) begin bad++; $display("[TB] FAIL stall_done got %0d want 41", done_cyc); end
    total++; if (n_out !== 32)    begin bad++; $display("[TB] FAIL stall_out_count got %0d want 32", n_out); end
    total++; if (in_xq.size() + bord_q.size() !== 0) begin bad++; $display("[TB] FAIL stall_leftover got %0d want 0", in_xq.size() + bord_q.size()); end
    flush_queues();
  endtask

  task automatic test_reset_mid_frame();
    push_frame();
    run_frame(-1, 0, 1'b0, 15);
    total++; if (rst_snap !== 26'd0) begin bad++; $display("[TB] FAIL mid_reset_outputs got %h want 0", rst_snap); end
    total++; if (n_out !== 10) begin bad++; $display("[TB] FAIL mid_reset_outs got %0d want 10", n_out); end
    total++; if (bord_q.size() !== 22) begin bad++; $display("[TB] FAIL mid_reset_out_left got %0d want 22", bord_q.size()); end
    total++; if (in_xq.size() !== 17) begin bad++; $display("[TB] FAIL mid_reset_in_left got %0d want 17", in_xq.size()); end
    flush_queues();
    push_frame();
    run_frame(-1, 0, 1'b0, -1);
    total++; if (sof_cyc !== 1)   begin bad++; $display("[TB] FAIL restart_sof got %0d want 1", sof_cyc); end
    total++; if (done_cyc !== 38) begin bad++; $display("[TB] FAIL restart_done got %0d want 38", done_cyc); end
    flush_queues();
  endtask

  task automatic test_ignored_start();
    push_frame();
    run_frame(-1, 0, 1'b1, -1);
    total++; if (sof_cnt !== 1)   begin bad++; $display("[TB] FAIL held_sof_count got %0d want 1", sof_cnt); end
    total++; if (done_cnt !== 1)  begin bad++; $display("[TB] FAIL held_done_count got %0d want 1", done_cnt); end
    total++; if (done_cyc !== 38) begin bad++; $display("[TB] FAIL held_done got %0d want 38", done_cyc); end
    mon_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    total++;
    if (oSof !== 1'b1 || oBusy !== 1'b1 || oInX !== 10'd0) begin
      bad++; $display("[TB] FAIL held_restart got sof=%0b busy=%0b x=%0d want 1 1 0", oSof, oBusy, oInX);
    end
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    flush_queues();
    mon_en = 1'b1;
  endtask

  task automatic test_stall_in_done();
    push_frame();
    run_frame(38, 2, 1'b0, -1);
    total++; if (done_cyc !== 38) begin bad++; $display("[TB] FAIL done_stall_cycle got %0d want 38", done_cyc); end
    total++; if (done_cnt !== 1)  begin bad++; $display("[TB] FAIL done_stall_count got %0d want 1", done_cnt); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("[TB] FAIL done_stall_busy got %0b want 0", busy_after); end
    flush_queues();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; mon_en = 1'b1;
    test_reset();
    test_nominal();
    test_stall();
    test_reset_mid_frame();
    test_ignored_start();
    test_stall_in_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got still running want finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/sobel_frame_ctrl.md
SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 Parameter IMG_W, default 640, pixels per line.
REQ-002 Parameter IMG_H, default 480, lines per frame.
REQ-003 Parameter LATENCY, default 537, datapath input-to-output delay in active cycles; legal range 1 .. IMG_W*IMG_H-1.
REQ-004 iClk  input  1  single clock; all logic on rising edge.
REQ-005 iRst  input  1  synchronous, active-high reset.
REQ-006 iStart  input  1  frame start request; sampled only in IDLE.
REQ-007 iStall  input  1  datapath stall; freezes the controller for that cycle.
REQ-008 oInValid  output  1  input pixel presented to datapath this cycle.
REQ-009 oInX  output  10  input pixel column, 0..IMG_W-1.
REQ-010 oInY  output  9  input pixel row, 0..IMG_H-1.
REQ-011 oSof  output  1  high with the first input pixel of the frame.
REQ-012 oEol  output  1  high with the last input pixel of each line.
REQ-013 oOutValid  output  1  datapath output pixel valid this cycle.
REQ-014 oOutBorder  output  1  current output pixel lies on the image border; downstream forces it to 0.
REQ-015 oBusy  output  1  high in every state except IDLE.
REQ-016 oDone  output  1  single-cycle frame-complete pulse.

Function
REQ-017 States: IDLE, FEED, DRAIN, DONE; encoding is implementation choice.
REQ-018 IDLE: iStart=1 moves the state to FEED on the next edge; all outputs except oBusy remain 0.
REQ-019 An active cycle is any cycle in FEED or DRAIN with iStall=0; a stall cycle holds every counter, the state and the latency count, and forces oInValid=0 and oOutValid=0.
REQ-020 FEED: oInValid=1 on every active cycle; oInX/oInY advance in raster order, X wrapping IMG_W-1 -> 0 with Y incrementing.
REQ-021 oSof=1 only on the active cycle with X=0 and Y=0; oEol=1 on the active cycle with X=IMG_W-1.
REQ-022 FEED -> DRAIN after the active cycle presenting X=IMG_W-1, Y=IMG_H-1 (exactly IMG_W*IMG_H input pixels).
REQ-023 Latency counter starts at the first active FEED cycle; oOutValid first asserts on the active cycle exactly LATENCY active cycles after the oSof cycle.
REQ-024 Once started, oOutValid=1 on every active cycle until IMG_W*IMG_H outputs have been issued, whether in FEED or DRAIN.
REQ-025 Internal output X/Y counters track oOutValid in raster order; oOutBorder=1 with oOutValid when outX=0, outX=IMG_W-1, outY=0 or outY=IMG_H-1, else 0.
REQ-026 DRAIN -> DONE after the active cycle issuing output IMG_W*IMG_H; DONE lasts one cycle with oDone=1, then returns to IDLE.
REQ-027 iStart while not in IDLE is ignored; iStart in DONE is also ignored.
REQ-028 iStall has no effect in IDLE or DONE; the DONE pulse is never stretched.
REQ-029 Counters wrap to 0 at frame end, so a new frame always starts at X=0, Y=0.

Reset
REQ-030 iRst=1 at any edge forces IDLE, clears all counters and drives every output to 0 on the next cycle, including mid-frame and during stalls.
REQ-031 iRst has priority over iStart and iStall in the same cycle.

Verification (IMG_W=8, IMG_H=4, LATENCY=5)
REQ-032 Nominal frame: iStart pulse, no stall -> oSof in cycle 1; 32 oInValid cycles; oOutValid cycles 6..37; oDone pulse in cycle 38; oBusy low in cycle 39.
REQ-033 Border map: nominal frame -> oOutBorder=1 for exactly 20 of the 32 outputs; interior (1..6, 1..2) pixels give 0.
REQ-034 Stall: iStall=1 for 3 cycles during FEED at X=3, Y=1 -> oInX holds 3 and oInValid=0 for those 3 cycles; oDone is 3 cycles late; output count stays 32.
REQ-035 Reset mid-frame: iRst at output pixel 10 -> next cycle all outputs are 0 in IDLE; the following iStart restarts at X=0, Y=0 with oSof.
REQ-036 Ignored start: iStart held high for the whole frame -> exactly one frame runs, oDone pulses once, and a new frame starts after the return to IDLE.
REQ-037 Eol/wrap: nominal frame -> oEol=1 four times, at input indices 7, 15, 23 and 31; oInY goes 0 -> 1 right after the first.
